ctrl_dcache: RTL and testbench
==============================

// Module: ctrl_dcache
// PURPOSE
//  Single-cycle ARM-LP (LEGv8 subset) main decoder plus word data memory. Decodes the
//  32-bit instruction into datapath controls and register indices; the decoded
//  memRead/memWrite drive the internal data store. Sits beside the ALU: address comes
//  from the ALU result, readData feeds the write-back mux (selected by memToReg).
// PARAMETERS
//  DATA_W   32  data word width (writeData/readData/memory word)
//  DEPTH    64  number of memory words (power of two)
// PORTS
//  clock               in   1       rising-edge clock
//  reset               in   1       asynchronous, active-high reset
//  instruction         in   32      current instruction word
//  address             in   32      byte address (ALU result)
//  writeData           in   DATA_W  store data
//  readData            out  DATA_W  registered load data
//  unconditionalBranch out  1       B taken
//  branch              out  1       CBZ conditional branch
//  memRead             out  1       load enable
//  memToReg            out  1       write-back selects readData
//  aluOP               out  2       00 add (LD/ST), 01 pass/zero-test (CBZ), 10 R-type funct
//  memWrite            out  1       store enable
//  aluSRC              out  1       ALU B operand = immediate
//  regWrite            out  1       register file write enable
//  readRegister1       out  5       Rn = instruction[9:5]
//  readRegister2       out  5       Rm [20:16] for R-type, else Rt [4:0]
//  writeRegister       out  5       Rd/Rt = instruction[4:0]
// BEHAVIOUR
//  Decode: purely combinational, unaffected by clock/reset. Match on instruction[31:21]:
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> regWrite=1, aluOP=10
//   LDUR 11111000010 -> memRead=1, memToReg=1, regWrite=1, aluSRC=1, aluOP=00
//   STUR 11111000000 -> memWrite=1, aluSRC=1, aluOP=00
//   CBZ  [31:24]=10110100 -> branch=1, aluOP=01
//   B    [31:26]=000101   -> unconditionalBranch=1
//   any other encoding -> all control outputs 0 (NOP); register fields still driven.
//  Unlisted controls are 0 for each class. Register index outputs are always field-derived.
//  Memory: word index = address[log2(DEPTH)+1:2]; address[1:0] ignored (no misalign
//   fault); upper address bits ignored (index wraps modulo DEPTH).
//  Write: at rising clock with memWrite=1, mem[index] <= writeData.
//  Read: at rising clock with memRead=1, readData <= mem[index]; latency 1 cycle;
//   readData holds its value when memRead=0. Read returns pre-write content if a write
//   to the same index lands on the same edge (cannot occur via decode; still required).
//  Reset (async, any time): readData=0 and every memory word=0 immediately; no write or
//   read occurs on an edge while reset is high; operation resumes on the first edge after
//   deassertion. memToReg is not used internally.
// STRUCTURE
//  Package ctrl_pkg: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR,
//   OP_CBZ, OP_B) and aluOP encodings (ALUOP_ADD, ALUOP_CBZ, ALUOP_RTYPE).
//  Sub-module instr_decode: combinational decoder; memory array and read register inline.
// TESTING
//  Reset: pulse reset -> readData=0; LDUR 0xF8400025 at address 0x0 -> readData=0 next edge.
//  ADD X3,X1,X2 0x8B020023 -> regWrite=1, aluOP=10, aluSRC=0, mem ctrl 0, rr1=1, rr2=2, wr=3.
//  STUR 0xF8000022, address=0x8, writeData=0xDEADBEEF -> memWrite=1, aluSRC=1, rr2=2;
//   then LDUR 0xF8400025 at 0x8 -> memRead=memToReg=regWrite=1, wr=5, readData=0xDEADBEEF after 1 edge.
//  Wrap: store 0x12345678 at 0x100 (DEPTH=64) -> load at 0x0 returns 0x12345678; load at 0x3 same.
//  CBZ 0xB4000007 -> branch=1, aluOP=01, rr2=7, regWrite=0; B 0x14000010 -> only unconditionalBranch=1.
//  0x00000000 -> all controls 0; reset raised mid-STUR -> no write, readData=0 at once.

Source files
------------

// File: rtl/ctrl_dcache_pkg.sv
// Shared constants for the LEGv8-subset main decoder and its data store.
// Holds opcode patterns, ALU operation encodings and a small R-type helper.
// Pure definitions only; no logic is elaborated from this file.
package ctrl_pkg;

    typedef logic [1:0] aluop_t;

    // Full 11-bit opcodes, matched against instruction[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Short opcodes: CBZ matches instruction[31:24], B matches instruction[31:26]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // ALU operation selects handed to the ALU control stage
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_CBZ   = 2'b01;
    localparam aluop_t ALUOP_RTYPE = 2'b10;

    // True for the four register-register arithmetic/logic encodings
    function automatic logic is_rtype(input logic [10:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_AND) || (opcode == OP_ORR);
    endfunction

endpackage

// File: rtl/ctrl_dcache_if.sv
// Bundle of instruction/address/data inputs and decoded control outputs.
// The master side drives the instruction word, address and store data.
// The slave side (the decoder + data store) returns controls and load data.
interface ctrl_dcache_if
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic [31:0]       instruction;
    logic [31:0]       address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              unconditionalBranch;
    logic              branch;
    logic              memRead;
    logic              memToReg;
    aluop_t            aluOP;
    logic              memWrite;
    logic              aluSRC;
    logic              regWrite;
    logic [4:0]        readRegister1;
    logic [4:0]        readRegister2;
    logic [4:0]        writeRegister;

    modport master (
        output instruction, address, writeData,
        input  readData, unconditionalBranch, branch, memRead, memToReg,
               aluOP, memWrite, aluSRC, regWrite,
               readRegister1, readRegister2, writeRegister
    );

    modport slave (
        input  instruction, address, writeData,
        output readData, unconditionalBranch, branch, memRead, memToReg,
               aluOP, memWrite, aluSRC, regWrite,
               readRegister1, readRegister2, writeRegister
    );

endinterface

// File: rtl/ctrl_dcache_instr_decode.sv
// Main decoder: instruction fields -> datapath controls and register indices.
// Purely combinational, zero latency; independent of clock and reset.
// Unrecognised opcodes decode as a NOP (all controls low, indices still driven).
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [10:0] opcode,     // instruction[31:21]
    input  logic [4:0]  rm,         // instruction[20:16]
    input  logic [4:0]  rn,         // instruction[9:5]
    input  logic [4:0]  rt,         // instruction[4:0]
    output logic        unconditionalBranch,
    output logic        branch,
    output logic        memRead,
    output logic        memToReg,
    output aluop_t      aluOP,
    output logic        memWrite,
    output logic        aluSRC,
    output logic        regWrite,
    output logic [4:0]  readRegister1,
    output logic [4:0]  readRegister2,
    output logic [4:0]  writeRegister
);

    logic rtype;
    assign rtype = is_rtype(opcode);

    // Control decode: every class starts from the all-zero NOP pattern
    always_comb begin
        unconditionalBranch = 1'b0;
        branch              = 1'b0;
        memRead             = 1'b0;
        memToReg            = 1'b0;
        aluOP               = ALUOP_ADD;
        memWrite            = 1'b0;
        aluSRC              = 1'b0;
        regWrite            = 1'b0;
        if (rtype) begin
            regWrite = 1'b1;
            aluOP    = ALUOP_RTYPE;
        end else if (opcode == OP_LDUR) begin
            memRead  = 1'b1;
            memToReg = 1'b1;
            regWrite = 1'b1;
            aluSRC   = 1'b1;
        end else if (opcode == OP_STUR) begin
            memWrite = 1'b1;
            aluSRC   = 1'b1;
        end else if (opcode[10:3] == OP_CBZ) begin
            branch = 1'b1;
            aluOP  = ALUOP_CBZ;
        end else if (opcode[10:5] == OP_B) begin
            unconditionalBranch = 1'b1;
        end
    end

    // Register indices come straight from the fields; Rm only for R-type
    always_comb begin
        readRegister1 = rn;
        readRegister2 = rtype ? rm : rt;
        writeRegister = rt;
    end

endmodule

// File: rtl/ctrl_dcache.sv
// Decoder plus word-addressed data store; decode is combinational.
// Loads return data one clock after memRead; stores commit on the same edge.
// No stalls: every access completes in one cycle; reset clears array and readData.
module ctrl_dcache
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
)(
    input  logic         clock,
    input  logic         reset,
    ctrl_dcache_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] read_q;
    logic [IDX_W-1:0]  index;

    // Byte offset bits are dropped and high bits wrap modulo DEPTH
    assign index = bus.address[IDX_W+1:2];

    instr_decode u_decode (
        .opcode              (bus.instruction[31:21]),
        .rm                  (bus.instruction[20:16]),
        .rn                  (bus.instruction[9:5]),
        .rt                  (bus.instruction[4:0]),
        .unconditionalBranch (bus.unconditionalBranch),
        .branch              (bus.branch),
        .memRead             (bus.memRead),
        .memToReg            (bus.memToReg),
        .aluOP               (bus.aluOP),
        .memWrite            (bus.memWrite),
        .aluSRC              (bus.aluSRC),
        .regWrite            (bus.regWrite),
        .readRegister1       (bus.readRegister1),
        .readRegister2       (bus.readRegister2),
        .writeRegister       (bus.writeRegister)
    );

    // Store path: reset wipes every word, otherwise write on memWrite
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.memWrite) begin
            mem[index] <= bus.writeData;
        end
    end

    // Load register: captures the pre-edge word, holds when memRead is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_q <= '0;
        end else if (bus.memRead) begin
            read_q <= mem[index];
        end
    end

    assign bus.readData = read_q;

endmodule

// File: tb/tb_ctrl_dcache.sv
// Self-checking bench: directed scenarios then randomized instruction traffic.
// Expected controls and load data come from a table-level model with a plain array.
// Inputs change on the falling edge; outputs are sampled 1 time unit after edges.
module tb_ctrl_dcache;

    localparam int DEPTH = 64;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd;

    ctrl_dcache_if #(.DATA_W(32)) bus ();

    ctrl_dcache #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected controls packed as {ub, br, mr, m2r, aluop[1:0], mw, asrc, rw}
    function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
        logic [10:0] op;
        op = ins[31:21];
        case (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return 9'b0000_10_001;
            11'b11111000010:                  return 9'b0011_00_011;
            11'b11111000000:                  return 9'b0000_00_110;
            default: begin
                if (ins[31:24] == 8'hB4)          return 9'b0100_01_000;
                else if (ins[31:26] == 6'b000101) return 9'b1000_00_000;
                else                              return 9'b0000_00_000;
            end
        endcase
    endfunction

    function automatic logic ref_rtype(input logic [31:0] ins);
        return ins[31:21] == 11'b10001011000 || ins[31:21] == 11'b11001011000 ||
               ins[31:21] == 11'b10001010000 || ins[31:21] == 11'b10101010000;
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {bus.unconditionalBranch, bus.branch, bus.memRead, bus.memToReg,
                bus.aluOP, bus.memWrite, bus.aluSRC, bus.regWrite};
    endfunction

    // Apply one instruction for one cycle, checking decode and resulting load data
    task automatic step(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] wd);
        logic [8:0] e;
        int         idx;
        bus.instruction = ins;
        bus.address     = addr;
        bus.writeData   = wd;
        #1;
        e = ref_ctrl(ins);
        check("ctrl", {23'd0, dut_ctrl()}, {23'd0, e});
        check("rr1", {27'd0, bus.readRegister1}, {27'd0, ins[9:5]});
        check("rr2", {27'd0, bus.readRegister2},
              {27'd0, ref_rtype(ins) ? ins[20:16] : ins[4:0]});
        check("wr", {27'd0, bus.writeRegister}, {27'd0, ins[4:0]});
        @(posedge clock);
        idx = int'((addr / 4) % DEPTH);
        if (e[6]) m_rd = m_mem[idx];
        if (e[2]) m_mem[idx] = wd;
        #1;
        check("rdata", bus.readData, m_rd);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 8))
            0: ins[31:21] = 11'b10001011000;
            1: ins[31:21] = 11'b11001011000;
            2: ins[31:21] = 11'b10001010000;
            3: ins[31:21] = 11'b10101010000;
            4: ins[31:21] = 11'b11111000010;
            5: ins[31:21] = 11'b11111000000;
            6: ins[31:24] = 8'hB4;
            7: ins[31:26] = 6'b000101;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_rd  = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        reset = 1'b1;
        bus.instruction = '0;
        bus.address     = '0;
        bus.writeData   = '0;
        #12;
        check("reset_rdata", bus.readData, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Load from cleared memory
        step(32'hF8400025, 32'h0, 32'h0);
        check("ldur_after_reset", bus.readData, 32'h0);

        // ADD X3,X1,X2
        step(32'h8B020023, 32'h0, 32'h0);

        // Store then load back
        bus.instruction = 32'hF8000022;
        #1;
        check("stur_memwrite", {31'd0, bus.memWrite}, 32'd1);
        check("stur_rr2", {27'd0, bus.readRegister2}, 32'd2);
        step(32'hF8000022, 32'h8, 32'hDEADBEEF);
        step(32'hF8400025, 32'h8, 32'h0);
        check("ldur_deadbeef", bus.readData, 32'hDEADBEEF);

        // Hold: non-load instruction keeps readData
        step(32'h8B020023, 32'h0, 32'h0);
        check("rdata_hold", bus.readData, 32'hDEADBEEF);

        // Index wrap and ignored byte offset
        step(32'hF8000022, 32'h100, 32'h12345678);
        step(32'hF8400025, 32'h0, 32'h0);
        check("wrap_0x0", bus.readData, 32'h12345678);
        step(32'hF8400025, 32'h8, 32'h0);
        step(32'hF8400025, 32'h3, 32'h0);
        check("wrap_0x3", bus.readData, 32'h12345678);

        // Branches and NOP
        step(32'hB4000007, 32'h0, 32'h0);
        step(32'h14000010, 32'h0, 32'h0);
        step(32'h00000000, 32'h0, 32'h0);
        check("nop_ctrl", {23'd0, dut_ctrl()}, 32'd0);

        // Reset raised in the middle of a store
        step(32'hF8000022, 32'h20, 32'h000055AA);
        step(32'hF8400025, 32'h20, 32'h0);
        check("pre_reset_load", bus.readData, 32'h000055AA);
        bus.instruction = 32'hF8000022;
        bus.address     = 32'h24;
        bus.writeData   = 32'hCAFEF00D;
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_rdata", bus.readData, 32'h0);
        @(posedge clock);
        #1;
        check("reset_held_rdata", bus.readData, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_rd = '0;
        step(32'hF8400025, 32'h24, 32'h0);
        check("no_write_in_reset", bus.readData, 32'h0);
        step(32'hF8400025, 32'h20, 32'h0);
        check("mem_cleared", bus.readData, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(rand_ins(), $urandom_range(0, 1023), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
